// File: rtl/stopwatch_ctrl_pkg.sv
// rtl/stopwatch_ctrl_pkg.sv - shared state/event encodings and defaults for the stopwatch controller
package stopwatch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_LAP   = 2'b11
    } sw_state_t;

    typedef enum logic [1:0] {
        EV_NONE  = 2'b00,
        EV_START = 2'b01,
        EV_LAP   = 2'b10,
        EV_CLEAR = 2'b11
    } sw_event_t;

    localparam int TICK_DIV_DEFAULT        = 500000;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;
    localparam int CNT_W_DEFAULT           = 32;

    function automatic logic is_running(input sw_state_t s);
        return (s == ST_RUN) || (s == ST_LAP);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_key_debounce.sv
// rtl/stopwatch_ctrl_key_debounce.sv - synchronise and debounce one active-low key, emit a press pulse
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 32
) (
    input  logic clk,
    input  logic key_reset,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge key_reset) begin
        if (!key_reset) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            level   <= 1'b1;
            level_d <= 1'b1;
            press   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= key_n;
            sync2   <= sync1;
            level_d <= level;
            // Only the 1->0 flip of the accepted level is a press; release is silent.
            press   <= level_d & ~level;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt   <= '0;
                level <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch sequencer: key arbitration, IDLE/RUN/PAUSE/LAP FSM, tick prescaler, strobes
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int TICK_DIV        = TICK_DIV_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = CNT_W_DEFAULT
) (
    input  logic       clk,
    input  logic       key_reset,
    input  logic       key_start_pause,
    input  logic       key_lap,
    input  logic       key_clear,
    output logic       tick,
    output logic       counter_clear,
    output logic       display_load,
    output logic [1:0] state,
    output logic       led_run,
    output logic       led_frozen
);

    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(TICK_DIV - 1);

    logic [2:0]       key_level;
    logic [2:0]       key_press;
    sw_event_t        ev;
    sw_state_t        cur;
    sw_state_t        nxt;
    logic             clear_now;
    logic [CNT_W-1:0] presc;
    logic [CNT_W-1:0] presc_next;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_start (
        .clk(clk), .key_reset(key_reset), .key_n(key_start_pause),
        .level(key_level[0]), .press(key_press[0])
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_lap (
        .clk(clk), .key_reset(key_reset), .key_n(key_lap),
        .level(key_level[1]), .press(key_press[1])
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_clear (
        .clk(clk), .key_reset(key_reset), .key_n(key_clear),
        .level(key_level[2]), .press(key_press[2])
    );

    // A press is honoured only while its key is still accepted as held down.
    always_comb begin
        logic [2:0] held_press;
        held_press = key_press & ~key_level;
        ev = EV_NONE;
        if (held_press[0])      ev = EV_START;
        else if (held_press[1]) ev = EV_LAP;
        else if (held_press[2]) ev = EV_CLEAR;
    end

    always_comb begin
        nxt       = cur;
        clear_now = 1'b0;
        case (cur)
            ST_IDLE: begin
                if (ev == EV_START)      nxt = ST_RUN;
                else if (ev == EV_CLEAR) clear_now = 1'b1;
            end
            ST_RUN: begin
                if (ev == EV_START)    nxt = ST_PAUSE;
                else if (ev == EV_LAP) nxt = ST_LAP;
            end
            ST_LAP: begin
                if (ev == EV_START)    nxt = ST_PAUSE;
                else if (ev == EV_LAP) nxt = ST_RUN;
            end
            default: begin
                if (ev == EV_START) begin
                    nxt = ST_RUN;
                end else if (ev == EV_CLEAR) begin
                    nxt       = ST_IDLE;
                    clear_now = 1'b1;
                end
            end
        endcase
    end

    // Prescaler advances on the current state, so a pause holds sub-tick progress.
    always_comb begin
        presc_next = presc;
        if (clear_now || cur == ST_IDLE)    presc_next = '0;
        else if (is_running(cur))           presc_next = (presc == LAST_TICK) ? '0 : presc + 1'b1;
    end

    always_ff @(posedge clk or negedge key_reset) begin
        if (!key_reset) begin
            cur           <= ST_IDLE;
            presc         <= '0;
            tick          <= 1'b0;
            counter_clear <= 1'b0;
            display_load  <= 1'b0;
            led_run       <= 1'b0;
            led_frozen    <= 1'b0;
        end else begin
            cur           <= nxt;
            presc         <= presc_next;
            tick          <= is_running(nxt) && (presc_next == LAST_TICK);
            counter_clear <= clear_now;
            display_load  <= (tick && cur == ST_RUN) || counter_clear
                             || (cur == ST_LAP && nxt != ST_LAP);
            led_run       <= is_running(nxt);
            led_frozen    <= (nxt == ST_LAP);
        end
    end

    assign state = cur;

endmodule
